pss_timing_tracker: RTL and testbench

- Sits directly downstream of the PSS correlator / peak detector chain, consuming its single-cycle peak pulses at the decimated (post-CIC) sample rate.
- Qualifies peaks against the expected SSB periodicity with a search → verify → locked state machine.
- Flywheels over missed peaks and emits a lock flag, a per-SSB timing strobe and the measured period error.
- The period error feeds the later CFO/timing loop.

---
 rtl/pss_timing_tracker.sv | 166 ++++++++++++++++
 tb/tb_pss_timing_tracker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pss_timing_tracker.sv
// PSS peak qualifier: search/verify/locked tracking of SSB periodicity with
// flywheel over missed peaks, SSB strobe and measured period error.
module pss_timing_tracker #(
  parameter int unsigned SSB_PERIOD  = 38400,
  parameter int unsigned TOLERANCE   = 2,
  parameter int unsigned CONFIRM_CNT = 3,
  parameter int unsigned MISS_LIMIT  = 2,
  parameter int unsigned CNT_DW      = $clog2(SSB_PERIOD + TOLERANCE + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     s_axis_in_tvalid,
  input  logic                     peak_detected_i,
  output logic                     locked_o,
  output logic [1:0]               state_o,
  output logic                     ssb_start_o,
  output logic                     ssb_flywheel_o,
  output logic signed [CNT_DW:0]   period_err_o,
  output logic                     period_err_valid_o,
  output logic [CNT_DW-1:0]        sample_cnt_o
);

  localparam int unsigned ERR_W  = CNT_DW + 1;
  localparam int unsigned CONF_W = $clog2(CONFIRM_CNT + 1);
  localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);

  localparam logic [CNT_DW-1:0] WIN_LO  = CNT_DW'(SSB_PERIOD - TOLERANCE);
  localparam logic [CNT_DW-1:0] WIN_HI  = CNT_DW'(SSB_PERIOD + TOLERANCE);
  localparam logic [CNT_DW-1:0] CNT_TOL = CNT_DW'(TOLERANCE);
  localparam logic [CNT_DW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_DW-1:0]  cnt_q, cnt_d;
  logic [CONF_W-1:0]  confirm_q, confirm_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               locked_q, locked_d;
  logic               ssb_start_q, ssb_start_d;
  logic               ssb_fly_q, ssb_fly_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               err_valid_q, err_valid_d;

  logic               in_win;
  logic               timeout;
  logic [CNT_DW-1:0]  cnt_inc;
  logic [CONF_W-1:0]  confirm_inc;
  logic [MISS_W-1:0]  miss_inc;
  logic [ERR_W-1:0]   err_meas;

  // Peak qualification, flywheel and counter control.
  always_comb begin
    in_win      = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
    timeout     = s_axis_in_tvalid && !peak_detected_i && (cnt_q == WIN_HI);
    cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_DW'(1);
    confirm_inc = confirm_q + CONF_W'(1);
    miss_inc    = miss_q + MISS_W'(1);
    err_meas    = ERR_W'(cnt_q) - ERR_W'(SSB_PERIOD);

    state_d     = state_q;
    cnt_d       = s_axis_in_tvalid ? cnt_inc : cnt_q;
    confirm_d   = confirm_q;
    miss_d      = miss_q;
    ssb_start_d = 1'b0;
    ssb_fly_d   = 1'b0;
    err_d       = err_q;
    err_valid_d = 1'b0;

    unique case (state_q)
      ST_SEARCH: begin
        if (peak_detected_i) begin
          state_d   = ST_VERIFY;
          cnt_d     = '0;
          confirm_d = CONF_W'(1);
        end
      end
      ST_VERIFY: begin
        if (peak_detected_i) begin
          cnt_d = '0;
          if (in_win) begin
            confirm_d   = confirm_inc;
            err_d       = err_meas;
            err_valid_d = 1'b1;
            if (confirm_inc == CONF_W'(CONFIRM_CNT)) begin
              state_d     = ST_LOCKED;
              miss_d      = '0;
              ssb_start_d = 1'b1;
            end
          end else begin
            // Out-of-window peak restarts verification from itself.
            confirm_d = CONF_W'(1);
          end
        end else if (timeout) begin
          state_d   = ST_SEARCH;
          confirm_d = '0;
        end
      end
      ST_LOCKED: begin
        if (peak_detected_i && in_win) begin
          cnt_d       = '0;
          miss_d      = '0;
          ssb_start_d = 1'b1;
          err_d       = err_meas;
          err_valid_d = 1'b1;
        end else if (timeout) begin
          // Virtual anchor at SSB_PERIOD: this sample is TOLERANCE past it.
          cnt_d = CNT_TOL;
          if (miss_inc == MISS_W'(MISS_LIMIT)) begin
            state_d   = ST_SEARCH;
            miss_d    = '0;
            confirm_d = '0;
          end else begin
            miss_d      = miss_inc;
            ssb_start_d = 1'b1;
            ssb_fly_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d   = ST_SEARCH;
        cnt_d     = '0;
        confirm_d = '0;
        miss_d    = '0;
      end
    endcase

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_SEARCH;
      cnt_q       <= '0;
      confirm_q   <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      ssb_start_q <= 1'b0;
      ssb_fly_q   <= 1'b0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      confirm_q   <= confirm_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      ssb_start_q <= ssb_start_d;
      ssb_fly_q   <= ssb_fly_d;
      err_q       <= err_d;
      err_valid_q <= err_valid_d;
    end
  end

  assign locked_o           = locked_q;
  assign state_o            = state_q;
  assign ssb_start_o        = ssb_start_q;
  assign ssb_flywheel_o     = ssb_fly_q;
  assign period_err_o       = err_q;
  assign period_err_valid_o = err_valid_q;
  assign sample_cnt_o       = cnt_q;

endmodule

// File: tb/tb_pss_timing_tracker.sv
// Directed bench for pss_timing_tracker: sample-index reference model checked
// every cycle, plus hand-computed snapshots at key points.
module tb_pss_timing_tracker;

  localparam int P      = 100;
  localparam int T      = 2;
  localparam int C      = 3;
  localparam int M      = 2;
  localparam int CNT_DW = 7;
  localparam int CMAX   = 127;

  logic                     clk = 1'b0;
  logic                     reset_ni = 1'b1;
  logic                     tvalid = 1'b0;
  logic                     peak = 1'b0;
  logic                     locked;
  logic [1:0]               state;
  logic                     ssb_start;
  logic                     ssb_fly;
  logic signed [CNT_DW:0]   period_err;
  logic                     err_valid;
  logic [CNT_DW-1:0]        sample_cnt;

  pss_timing_tracker #(
    .SSB_PERIOD (P),
    .TOLERANCE  (T),
    .CONFIRM_CNT(C),
    .MISS_LIMIT (M)
  ) dut (
    .clk_i             (clk),
    .reset_ni          (reset_ni),
    .s_axis_in_tvalid  (tvalid),
    .peak_detected_i   (peak),
    .locked_o          (locked),
    .state_o           (state),
    .ssb_start_o       (ssb_start),
    .ssb_flywheel_o    (ssb_fly),
    .period_err_o      (period_err),
    .period_err_valid_o(err_valid),
    .sample_cnt_o      (sample_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: counts are distances in valid samples from an anchor index.
  int m_mode, m_total, m_anchor, m_confirm, m_miss;
  int e_state, e_cnt, e_start, e_fly, e_err, e_errv, e_locked;

  always @(posedge clk or negedge reset_ni) begin
    int c;
    bit inw, to;
    if (!reset_ni) begin
      m_mode = 0; m_total = 0; m_anchor = 0; m_confirm = 0; m_miss = 0;
      e_state = 0; e_cnt = 0; e_start = 0; e_fly = 0; e_err = 0; e_errv = 0; e_locked = 0;
    end else begin
      c = m_total - m_anchor;
      if (c > CMAX) c = CMAX;
      if (tvalid) m_total = m_total + 1;
      inw = (c >= P - T) && (c <= P + T);
      to  = tvalid && !peak && (c == P + T);
      e_start = 0; e_fly = 0; e_errv = 0;
      if (m_mode == 0) begin
        if (peak) begin m_mode = 1; m_anchor = m_total; m_confirm = 1; end
      end else if (m_mode == 1) begin
        if (peak) begin
          m_anchor = m_total;
          if (inw) begin
            m_confirm = m_confirm + 1;
            e_err = c - P; e_errv = 1;
            if (m_confirm == C) begin m_mode = 2; m_miss = 0; e_start = 1; end
          end else m_confirm = 1;
        end else if (to) begin
          m_mode = 0; m_confirm = 0;
        end
      end else begin
        if (peak && inw) begin
          m_anchor = m_total; m_miss = 0; e_start = 1; e_err = c - P; e_errv = 1;
        end else if (to) begin
          m_anchor = m_total - T;
          if (m_miss + 1 == M) begin m_mode = 0; m_miss = 0; m_confirm = 0; end
          else begin m_miss = m_miss + 1; e_start = 1; e_fly = 1; end
        end
      end
      e_state  = m_mode;
      e_locked = (m_mode == 2) ? 1 : 0;
      e_cnt    = m_total - m_anchor;
      if (e_cnt > CMAX) e_cnt = CMAX;
    end
  end

  // Hand-computed snapshot request, written only by the stimulus.
  int lit_seq = 0, lit_id, lit_st, lit_cnt, lit_start, lit_fly, lit_errv, lit_err, lit_lk;
  int lit_seen = 0;
  bit chk_en = 1'b0;
  int n_vec = 0, n_mis = 0, cyc = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (chk_en) begin
      n_vec = n_vec + 1;
      if (int'(state) != e_state || int'(sample_cnt) != e_cnt || int'(ssb_start) != e_start ||
          int'(ssb_fly) != e_fly || int'(err_valid) != e_errv || int'(period_err) != e_err ||
          int'(locked) != e_locked) begin
        n_mis = n_mis + 1;
        $display("FAIL model cyc=%0d got st=%0d cnt=%0d start=%0b fly=%0b errv=%0b err=%0d lk=%0b want st=%0d cnt=%0d start=%0d fly=%0d errv=%0d err=%0d lk=%0d",
                 cyc, state, sample_cnt, ssb_start, ssb_fly, err_valid, period_err, locked,
                 e_state, e_cnt, e_start, e_fly, e_errv, e_err, e_locked);
      end
      if (lit_seq != lit_seen) begin
        lit_seen = lit_seq;
        n_vec = n_vec + 1;
        if (int'(state) != lit_st || int'(sample_cnt) != lit_cnt || int'(ssb_start) != lit_start ||
            int'(ssb_fly) != lit_fly || int'(err_valid) != lit_errv || int'(period_err) != lit_err ||
            int'(locked) != lit_lk) begin
          n_mis = n_mis + 1;
          $display("FAIL snapshot L%0d got st=%0d cnt=%0d start=%0b fly=%0b errv=%0b err=%0d lk=%0b want st=%0d cnt=%0d start=%0d fly=%0d errv=%0d err=%0d lk=%0d",
                   lit_id, state, sample_cnt, ssb_start, ssb_fly, err_valid, period_err, locked,
                   lit_st, lit_cnt, lit_start, lit_fly, lit_errv, lit_err, lit_lk);
        end
      end
    end
  end

  task automatic expect_lit(input int id, input int st, input int cnt, input int start,
                            input int fly, input int errv, input int err, input int lk);
    lit_id = id; lit_st = st; lit_cnt = cnt; lit_start = start;
    lit_fly = fly; lit_errv = errv; lit_err = err; lit_lk = lk;
    lit_seq = lit_seq + 1;
    @(negedge clk); #1;
  endtask

  task automatic tick(input logic v, input logic p);
    tvalid = v; peak = p;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1, 1'b0);
  endtask

  task automatic peak_after(input int k);
    idle(k);
    tick(1'b1, 1'b1);
  endtask

  initial begin
    #2 reset_ni = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_lit(0, 0, 0, 0, 0, 0, 0, 0);
    reset_ni = 1'b1;

    idle(130);                        // SEARCH counter saturates
    expect_lit(1, 0, 127, 0, 0, 0, 0, 0);
    tick(1'b1, 1'b1);                 // first candidate
    expect_lit(2, 1, 0, 0, 0, 0, 0, 0);
    peak_after(100);
    expect_lit(3, 1, 0, 0, 0, 1, 0, 0);
    peak_after(100);                  // third peak locks
    expect_lit(4, 2, 0, 1, 0, 1, 0, 1);
    peak_after(101);
    expect_lit(5, 2, 0, 1, 0, 1, 1, 1);
    peak_after(98);
    expect_lit(6, 2, 0, 1, 0, 1, -2, 1);

    idle(50); tick(1'b1, 1'b1);       // spurious mid-period peak ignored
    expect_lit(7, 2, 51, 0, 0, 0, -2, 1);
    idle(49); tick(1'b1, 1'b1);
    expect_lit(8, 2, 0, 1, 0, 1, 0, 1);

    idle(103);                        // single miss: flywheel strobe
    expect_lit(9, 2, 2, 1, 1, 0, 0, 1);
    peak_after(98);
    expect_lit(10, 2, 0, 1, 0, 1, 0, 1);

    idle(103); idle(101);             // two misses drop lock
    expect_lit(11, 0, 2, 0, 0, 0, 0, 0);

    tick(1'b1, 1'b1);
    peak_after(50);                   // early peak restarts verification
    expect_lit(12, 1, 0, 0, 0, 0, 0, 0);
    peak_after(100);
    peak_after(100);
    expect_lit(13, 2, 0, 1, 0, 1, 0, 1);

    idle(60);                         // tvalid gaps do not advance the count
    repeat (5) tick(1'b0, 1'b0);
    idle(40);
    tick(1'b0, 1'b1);
    expect_lit(14, 2, 0, 1, 0, 1, 0, 1);

    idle(30);
    #2 reset_ni = 1'b0;               // asynchronous reset between edges
    expect_lit(15, 0, 0, 0, 0, 0, 0, 0);
    reset_ni = 1'b1;

    tick(1'b1, 1'b1);
    idle(103);                        // VERIFY timeout back to SEARCH
    expect_lit(16, 0, 103, 0, 0, 0, 0, 0);
    tick(1'b1, 1'b1);
    peak_after(100);
    expect_lit(17, 1, 0, 0, 0, 1, 0, 0);
    peak_after(100);
    expect_lit(18, 2, 0, 1, 0, 1, 0, 1);

    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
